writeback_stage: RTL and testbench

- Final pipeline stage. Consumes the pre-writeback word and destination info from the stage before it.
- For loads, waits for the data-memory read response, then aligns and sign- or zero-extends the returned data.
- Produces the single register-file write port, plus a forwarding copy of it.
- Drives a stall back upstream while a load is outstanding.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/load_extract.sv | 47 ++++
 rtl/writeback_stage.sv | 118 +++++++++++
 tb/tb_writeback_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback state encoding, load width codes and datapath width.
package cpu_pkg;

   localparam int XLEN = 32;

   typedef enum logic {
      IDLE,
      WAIT_MEM
   } wb_state_e;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_e;

endpackage

// File: rtl/load_extract.sv
// Load data alignment and extension from a word-aligned read, plus legality check.
module load_extract
   import cpu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data,
   output logic        fault
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data  = '0;
      fault = 1'b0;
      case (funct3)
         LB:  data = {{24{byte_sel[7]}}, byte_sel};
         LBU: data = {24'd0, byte_sel};
         LH: begin
            data  = {{16{half_sel[15]}}, half_sel};
            fault = addr_lo[0];
         end
         LHU: begin
            data  = {16'd0, half_sel};
            fault = addr_lo[0];
         end
         LW: begin
            data  = rdata;
            fault = |addr_lo;
         end
         default: fault = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: completes non-loads directly, waits on memory for loads,
// drives the register-file write port, its forwarding copy and the upstream stall.
//   state    | meaning
//   IDLE     | ready for a new op; non-loads and faulting loads complete here
//   WAIT_MEM | legal load accepted, holding off upstream until mem_rvalid
module writeback_stage
   import cpu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pre_wb,
   input  logic [4:0]        in_rd,
   input  logic              in_reg_write,
   input  logic              in_is_load,
   input  logic [2:0]        in_load_funct3,
   input  logic [1:0]        in_addr_lo,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              fwd_valid,
   output logic [4:0]        fwd_rd,
   output logic [XLEN-1:0]   fwd_data,
   output logic              stall,
   output logic              load_fault,
   output logic [PERF_W-1:0] perf_stall_cycles
);

   wb_state_e       state, state_nxt;
   logic [4:0]      rd_q;
   logic [2:0]      funct3_q;
   logic [1:0]      addr_lo_q;
   logic            reg_write_q;
   logic            accept;
   logic [2:0]      ex_funct3;
   logic [1:0]      ex_addr_lo;
   logic [XLEN-1:0] ex_data;
   logic            ex_fault;

   assign in_ready = (state == IDLE);
   assign stall    = ~in_ready;
   assign accept   = in_valid && in_ready;

   // One extractor serves both uses: fault check on the incoming op while idle,
   // data extraction for the latched load while waiting.
   assign ex_funct3  = in_ready ? in_load_funct3 : funct3_q;
   assign ex_addr_lo = in_ready ? in_addr_lo     : addr_lo_q;

   load_extract u_extract (
      .funct3  (ex_funct3),
      .addr_lo (ex_addr_lo),
      .rdata   (mem_rdata),
      .data    (ex_data),
      .fault   (ex_fault)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept && in_is_load && !ex_fault) state_nxt = WAIT_MEM;
         WAIT_MEM: if (mem_rvalid) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we             <= 1'b0;
         rf_waddr          <= '0;
         rf_wdata          <= '0;
         load_fault        <= 1'b0;
         perf_stall_cycles <= '0;
         rd_q              <= '0;
         funct3_q          <= '0;
         addr_lo_q         <= '0;
         reg_write_q       <= 1'b0;
      end else begin
         rf_we      <= 1'b0;
         load_fault <= 1'b0;
         if (stall && (perf_stall_cycles != '1))
            perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
         if (accept) begin
            if (!in_is_load) begin
               rf_we    <= in_reg_write && (in_rd != 5'd0);
               rf_waddr <= in_rd;
               rf_wdata <= in_pre_wb;
            end else if (ex_fault) begin
               load_fault <= 1'b1;
            end else begin
               rd_q        <= in_rd;
               funct3_q    <= in_load_funct3;
               addr_lo_q   <= in_addr_lo;
               reg_write_q <= in_reg_write;
            end
         end else if ((state == WAIT_MEM) && mem_rvalid) begin
            rf_we    <= reg_write_q && (rd_q != 5'd0);
            rf_waddr <= rd_q;
            rf_wdata <= ex_data;
         end
      end
   end

   assign fwd_valid = rf_we;
   assign fwd_rd    = rf_waddr;
   assign fwd_data  = rf_wdata;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed table, hand sequences, random ops.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_pre_wb;
   logic [4:0]  in_rd;
   logic        in_reg_write, in_is_load;
   logic [2:0]  in_load_funct3;
   logic [1:0]  in_addr_lo;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        stall, load_fault;
   logic [31:0] perf_stall_cycles;

   int vectors = 0;
   int miscompares = 0;
   int exp_perf = 0;

   always #5 clk = ~clk;

   writeback_stage #(.XLEN(32), .PERF_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pre_wb(in_pre_wb),
      .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
      .in_load_funct3(in_load_funct3), .in_addr_lo(in_addr_lo),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .stall(stall), .load_fault(load_fault), .perf_stall_cycles(perf_stall_cycles)
   );

   typedef struct {
      logic        is_load;
      logic        reg_write;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [1:0]  addr_lo;
      logic [31:0] pre_wb;
      logic [31:0] rdata;
      int          delay;
      logic        exp_we;
      logic [31:0] exp_data;
      logic        exp_fault;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic rw, input logic [4:0] rd,
                               input logic [2:0] f3, input logic [1:0] a,
                               input logic [31:0] pre, input logic [31:0] rdat, input int dly,
                               input logic ewe, input logic [31:0] edat, input logic eflt);
      vec_t v;
      v.is_load = ld; v.reg_write = rw; v.rd = rd; v.f3 = f3; v.addr_lo = a;
      v.pre_wb = pre; v.rdata = rdat; v.delay = dly;
      v.exp_we = ewe; v.exp_data = edat; v.exp_fault = eflt;
      return v;
   endfunction

   // Reference: shift the word down to the addressed lane, then extend per width code.
   function automatic void ref_model(inout vec_t v);
      logic [31:0] sh;
      sh = v.rdata >> (8 * v.addr_lo);
      v.exp_fault = 1'b0;
      v.exp_data  = v.pre_wb;
      if (v.is_load) begin
         case (v.f3)
            3'd0: v.exp_data = {{24{sh[7]}}, sh[7:0]};
            3'd1: begin v.exp_data = {{16{sh[15]}}, sh[15:0]}; v.exp_fault = (v.addr_lo % 2) != 0; end
            3'd2: begin v.exp_data = v.rdata; v.exp_fault = v.addr_lo != 0; end
            3'd4: v.exp_data = sh & 32'h0000_00FF;
            3'd5: begin v.exp_data = sh & 32'h0000_FFFF; v.exp_fault = (v.addr_lo % 2) != 0; end
            default: v.exp_fault = 1'b1;
         endcase
      end
      v.exp_we = !v.exp_fault && v.reg_write && (v.rd != 0);
   endfunction

   task automatic drive(input vec_t v);
      in_valid = 1'b1; in_is_load = v.is_load; in_reg_write = v.reg_write;
      in_rd = v.rd; in_load_funct3 = v.f3; in_addr_lo = v.addr_lo;
      in_pre_wb = v.pre_wb; mem_rdata = v.rdata;
   endtask

   task automatic check_result(input string tag, input vec_t v);
      chk({tag, ".rf_we"}, 32'(rf_we), 32'(v.exp_we));
      chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(v.exp_we));
      chk({tag, ".load_fault"}, 32'(load_fault), 32'(v.exp_fault));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      if (!v.exp_fault) begin
         chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(v.rd));
         chk({tag, ".rf_wdata"}, rf_wdata, v.exp_data);
         chk({tag, ".fwd_data"}, fwd_data, v.exp_data);
      end
      chk({tag, ".perf"}, perf_stall_cycles, 32'(exp_perf));
   endtask

   task automatic do_op(input string tag, input vec_t v);
      @(negedge clk);
      drive(v);
      mem_rvalid = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      if (v.is_load && !v.exp_fault) begin
         for (int i = 1; i < v.delay; i++) begin
            chk({tag, ".stall_wait"}, 32'(stall), 32'd1);
            chk({tag, ".we_wait"}, 32'(rf_we), 32'd0);
            @(negedge clk);
         end
         chk({tag, ".stall_wait"}, 32'(stall), 32'd1);
         mem_rvalid = 1'b1;
         @(negedge clk);
         mem_rvalid = 1'b0;
         exp_perf += v.delay;
      end
      check_result(tag, v);
   endtask

   vec_t tbl[12];
   vec_t a, b, r;

   initial begin
      tbl[0]  = mk(0, 1, 5'd5,  3'd0, 2'd0, 32'h0001_2000, 32'h0,          1, 1, 32'h0001_2000, 0);
      tbl[1]  = mk(1, 1, 5'd7,  3'd0, 2'd3, 32'h0,         32'h80FF_FF7F, 3, 1, 32'hFFFF_FF80, 0);
      tbl[2]  = mk(1, 1, 5'd8,  3'd4, 2'd3, 32'h0,         32'h80FF_FF7F, 3, 1, 32'h0000_0080, 0);
      tbl[3]  = mk(1, 1, 5'd9,  3'd1, 2'd2, 32'h0,         32'h8001_1234, 2, 1, 32'hFFFF_8001, 0);
      tbl[4]  = mk(1, 1, 5'd10, 3'd5, 2'd2, 32'h0,         32'h8001_1234, 2, 1, 32'h0000_8001, 0);
      tbl[5]  = mk(1, 1, 5'd11, 3'd2, 2'd1, 32'h0,         32'h1234_5678, 1, 0, 32'h0,         1);
      tbl[6]  = mk(1, 1, 5'd12, 3'd3, 2'd0, 32'h0,         32'h1234_5678, 1, 0, 32'h0,         1);
      tbl[7]  = mk(0, 1, 5'd0,  3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0,          1, 0, 32'hDEAD_BEEF, 0);
      tbl[8]  = mk(1, 1, 5'd0,  3'd2, 2'd0, 32'h0,         32'hCAFE_F00D, 2, 0, 32'hCAFE_F00D, 0);
      tbl[9]  = mk(1, 1, 5'd13, 3'd2, 2'd0, 32'h0,         32'hA5A5_5A5A, 1, 1, 32'hA5A5_5A5A, 0);
      tbl[10] = mk(0, 0, 5'd14, 3'd0, 2'd0, 32'h1357_9BDF, 32'h0,          1, 0, 32'h1357_9BDF, 0);
      tbl[11] = mk(1, 1, 5'd15, 3'd5, 2'd1, 32'h0,         32'h1111_2222, 1, 0, 32'h0,         1);

      rst = 1'b1; in_valid = 1'b0; in_pre_wb = '0; in_rd = '0; in_reg_write = 1'b0;
      in_is_load = 1'b0; in_load_funct3 = '0; in_addr_lo = '0;
      mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.stall", 32'(stall), 32'd0);
      chk("reset.rf_we", 32'(rf_we), 32'd0);
      chk("reset.rf_waddr", 32'(rf_waddr), 32'd0);
      chk("reset.rf_wdata", rf_wdata, 32'd0);
      chk("reset.fwd_valid", 32'(fwd_valid), 32'd0);
      chk("reset.load_fault", 32'(load_fault), 32'd0);
      chk("reset.perf", perf_stall_cycles, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) do_op($sformatf("tbl%0d", i), tbl[i]);

      // back-to-back non-loads complete one per cycle
      a = mk(0, 1, 5'd3, 3'd0, 2'd0, 32'h0000_0AAA, 32'h0, 1, 1, 32'h0000_0AAA, 0);
      b = mk(0, 1, 5'd4, 3'd0, 2'd0, 32'h0000_0BBB, 32'h0, 1, 1, 32'h0000_0BBB, 0);
      @(negedge clk);
      drive(a);
      @(negedge clk);
      check_result("b2b.first", a);
      drive(b);
      @(negedge clk);
      in_valid = 1'b0;
      check_result("b2b.second", b);

      // reset while a load is outstanding, then a late response
      a = mk(1, 1, 5'd6, 3'd0, 2'd3, 32'h0, 32'h80FF_FF7F, 1, 0, 32'h0, 0);
      @(negedge clk);
      drive(a);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rstwait.stall", 32'(stall), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_perf = 0;
      @(negedge clk);
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("rstwait.rf_we", 32'(rf_we), 32'd0);
      chk("rstwait.in_ready", 32'(in_ready), 32'd1);
      chk("rstwait.perf", perf_stall_cycles, 32'd0);

      for (int i = 0; i < 60; i++) begin
         r.is_load   = $urandom_range(0, 1) == 1;
         r.reg_write = $urandom_range(0, 7) != 0;
         r.rd        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         r.f3        = 3'($urandom_range(0, 7));
         r.addr_lo   = 2'($urandom_range(0, 3));
         r.pre_wb    = $urandom;
         r.rdata     = $urandom;
         r.delay     = $urandom_range(1, 4);
         ref_model(r);
         do_op($sformatf("rnd%0d", i), r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
